// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core's DMEM port and data memory.
// Stores queue in a circular FIFO and retire in order over a valid/ready
// write port; loads read memory combinationally, overridden byte-exactly
// by the youngest queued store to the same doubleword.
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          core_addr,
    input  logic [DATA_W-1:0]          core_wdata,
    input  logic                       core_we,
    input  logic                       core_re,
    output logic [DATA_W-1:0]          core_rdata,
    output logic                       stall,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [ADDR_W-1:0]          mem_waddr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_wvalid,
    input  logic                       mem_wready,
    output logic [ADDR_W-1:0]          mem_raddr,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [DEPTH-1:0]  valid_reg,  valid_next;
    logic [PTR_W-1:0]  head_reg,   head_next;
    logic [PTR_W-1:0]  tail_reg,   tail_next;
    logic [CNT_W-1:0]  count_reg,  count_next;

    logic              full;
    logic              enq;
    logic              deq;
    logic [DEPTH-1:0]  match;

    // core_re is reserved for future load gating; loads forward regardless.
    logic              unused_core_re;
    assign unused_core_re = core_re;

    // Stall depends only on registered occupancy, so memory backpressure
    // never reaches the core's PC enable combinationally.
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign stall      = core_we && full;
    assign enq        = core_we && !full;
    assign empty      = (count_reg == '0);
    assign count      = count_reg;
    assign mem_wvalid = !empty;
    assign deq        = mem_wvalid && mem_wready;
    assign mem_waddr  = addr_mem[head_reg];
    assign mem_wdata  = data_mem[head_reg];
    assign mem_raddr  = core_addr;

    // Pointer, occupancy and entry-valid next-state.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        valid_next = valid_reg;
        if (deq) begin
            head_next            = head_reg + PTR_W'(1);
            valid_next[head_reg] = 1'b0;
        end
        if (enq) begin
            tail_next            = tail_reg + PTR_W'(1);
            valid_next[tail_reg] = 1'b1;
        end
        if (enq && !deq) begin
            count_next = count_reg + CNT_W'(1);
        end else if (deq && !enq) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Control state; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            valid_reg <= valid_next;
        end
    end

    // Entry payload storage; contents are qualified by valid_reg.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_reg] <= core_addr;
            data_mem[tail_reg] <= core_wdata;
        end
    end

    // Doubleword address match per occupied entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] &&
                (addr_mem[gi][ADDR_W-1:3] == core_addr[ADDR_W-1:3]);
        end
    endgenerate

    // Walk entries oldest to youngest so the youngest match wins.
    always_comb begin : fwd
        logic [PTR_W-1:0] idx;
        core_rdata = mem_rdata;
        idx        = head_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[idx]) begin
                core_rdata = data_mem[idx];
            end
            idx = idx + PTR_W'(1);
        end
    end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write store buffer between the single-cycle core's DMEM port and a data memory that accepts writes with a ready/valid handshake.
- Core stores (SD) are queued and retire to memory in order.
- Core loads (LD) read memory combinationally, with byte-exact forwarding from the youngest matching queued store.
- Decouples core store issue from memory write backpressure; exports a stall for the core's PC enable.

Parameters:
- DEPTH, 4, number of store entries; power of two, >= 2.
- ADDR_W, 64, address width.
- DATA_W, 64, data width; doubleword accesses only.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- core_addr  input  ADDR_W  load/store address (core ALU result).
- core_wdata  input  DATA_W  store data.
- core_we  input  1  store request this cycle.
- core_re  input  1  load request this cycle.
- core_rdata  output  DATA_W  load data, combinational.
- stall  output  1  store cannot be accepted this cycle; core must hold PC.
- empty  output  1  no entries queued (used for fences).
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- mem_waddr  output  ADDR_W  head entry address.
- mem_wdata  output  DATA_W  head entry data.
- mem_wvalid  output  1  head entry valid.
- mem_wready  input  1  memory accepts write this cycle.
- mem_raddr  output  ADDR_W  load read address; equals core_addr.
- mem_rdata  input  DATA_W  memory read data, combinational.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: count=0, empty=1, mem_wvalid=0, stall=0, and all entry valid bits cleared.
- Reset mid-drain: queued stores are discarded and not written; mem_wvalid deasserts the cycle after rst is sampled.
- Storage: circular FIFO of {addr, data} with head/tail pointers, plus a separate occupancy counter. Pointers wrap modulo DEPTH.
- Enqueue: on a rising clk edge with core_we=1 and stall=0, {core_addr, core_wdata} is written at the tail and the tail advances.
- Stall condition: stall = core_we && (count==DEPTH).
  - Combinational from core_we and registered count only. No dependence on mem_wready, so no comb path from memory to core.
- Drain: mem_wvalid = !empty. mem_waddr/mem_wdata come from the head entry.
- Drain handshake: a write completes when mem_wvalid && mem_wready; the head then advances on that edge.
  - Head address/data are stable while mem_wvalid=1 and mem_wready=0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - When count==DEPTH, a dequeue does not unblock the same cycle's store; stall is still 1 and the store is accepted next cycle.
- Latency: a store is visible to mem_wvalid at the earliest one cycle after enqueue (registered entry).
- Load forwarding:
  - mem_raddr = core_addr.
  - A queued entry matches when its addr[ADDR_W-1:3] equals core_addr[ADDR_W-1:3].
  - If any entry matches, core_rdata = data of the youngest matching entry (closest to the tail). Otherwise core_rdata = mem_rdata.
  - Forwarding is purely combinational and independent of core_re. core_re is accepted only for future use and does not gate anything.
  - A store enqueued on the same edge is NOT visible to a load in that same cycle.
  - An entry dequeued on the current edge remains forwardable until that edge.
- Ordering: stores retire to memory strictly in enqueue order. Duplicate addresses are not merged.

Test Plan:
- Reset then 2 stores, memory ready held low:
  - Stimulus: rst 1 cycle; SD 0x100=0xAAAA, SD 0x108=0xBBBB; mem_wready=0.
  - Required: count=2, stall=0, mem_wvalid=1, mem_waddr=0x100 held stable.
  - Then mem_wready=1 for 2 cycles: writes 0x100 then 0x108 in order, and empty=1 afterwards.
- Full and stall:
  - Stimulus: DEPTH=4, mem_wready=0, 5 consecutive stores.
  - Required: stall=1 on the 5th with count=4. Raise mem_wready one cycle: count stays 4 that cycle, the 5th store is accepted the next cycle, and data order is preserved.
- Youngest-match forwarding:
  - Stimulus: queue 0x200=0x11 then 0x200=0x22 (mem_wready=0); LD 0x200 with mem_rdata=0x99.
  - Required: core_rdata=0x22.
  - LD 0x208 returns 0x99. LD 0x204 (same doubleword) returns 0x22.
- Pointer wrap-around:
  - Stimulus: 10 stores with mem_wready toggling every cycle.
  - Required: memory receives all 10 in order, and count never exceeds 4 or underflows.
- Reset mid-operation:
  - Stimulus: 3 stores queued, assert rst while mem_wvalid=1.
  - Required: next cycle mem_wvalid=0, count=0, and LD of a queued address returns mem_rdata.
- Same-cycle dequeue and load:
  - Stimulus: single entry 0x300=0x55, mem_wready=1, LD 0x300 in the same cycle, mem_rdata=0x00.
  - Required: core_rdata=0x55 that cycle; the next cycle the buffer is empty.
